ita_bus_arb: RTL and testbench



---
 rtl/ita_bus_arb_pkg.sv | 24 ++
 rtl/ita_arb_rr2.sv | 17 +
 rtl/ita_bus_arb.sv | 176 +++++++++++++++++
 tb/tb_ita_bus_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_bus_arb_pkg.sv
// Shared definitions for the intagent register-port arbiter.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package ita_bus_arb_pkg;

    localparam int PC_SIZE     = 32;
    localparam int XLEN        = 32;
    localparam int ARB_AW      = PC_SIZE;
    localparam int ARB_DW      = XLEN;
    localparam int ARB_TIMEOUT = 16;
    localparam int ARB_TOW     = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // A request must carry exactly one of wr/rd; anything else is rejected.
    function automatic logic req_malformed(input logic wr, input logic rd);
        return (wr == rd);
    endfunction

endpackage

// File: rtl/ita_arb_rr2.sv
// Two-way round-robin grant: picks the single requester, or rr_ptr on a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module ita_arb_rr2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    // Tie goes to the pointer; otherwise the lone requester (req[1] set means master 1).
    always_comb begin
        gnt_vld = |req;
        gnt_idx = (req == 2'b11) ? rr_ptr : req[1];
    end

endmodule

// File: rtl/ita_bus_arb.sv
// Two-master to one-slave sequencer for the intagent register port, with timeout and malformed-request rejection.
// Latency: grant in IDLE -> s_valid next cycle -> mN_ready the cycle after s_ready (3 cycles minimum per access).
// Backpressure: slave stalls by withholding s_ready up to TIMEOUT cycles; masters hold mN_valid until mN_ready.
module ita_bus_arb
    import ita_bus_arb_pkg::*;
#(
    parameter int AW      = ARB_AW,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT,
    parameter int TOW     = ARB_TOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_valid,
    input  logic          m0_wr,
    input  logic          m0_rd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ready,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_valid,
    input  logic          m1_wr,
    input  logic          m1_rd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ready,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          s_valid,
    output logic          s_wr,
    output logic          s_rd,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic          arb_busy,
    output logic          arb_owner
);

    localparam logic [TOW-1:0] TCNT_LAST = TOW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    logic          rr_ptr_q;
    logic          owner_q;
    logic          wr_q, rd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [TOW-1:0] tcnt_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;

    logic          gnt_vld, gnt_idx;
    logic          sel_wr, sel_rd;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          tmo_hit;
    logic          in_busy, in_resp;

    ita_arb_rr2 u_rr2 (
        .req     ({m1_valid, m0_valid}),
        .rr_ptr  (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Request fields of whichever master the round-robin picked this cycle.
    always_comb begin
        sel_wr    = gnt_idx ? m1_wr    : m0_wr;
        sel_rd    = gnt_idx ? m1_rd    : m0_rd;
        sel_addr  = gnt_idx ? m1_addr  : m0_addr;
        sel_wdata = gnt_idx ? m1_wdata : m0_wdata;
        tmo_hit   = (tcnt_q == TCNT_LAST);
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs; slave handshake beats the timeout when both land together.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    state_d = req_malformed(sel_wr, sel_rd) ? ARB_RESP : ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (s_ready || tmo_hit) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        in_busy   = (state_q == ARB_BUSY);
        in_resp   = (state_q == ARB_RESP);

        s_valid   = in_busy;
        s_wr      = in_busy & wr_q;
        s_rd      = in_busy & rd_q;
        s_addr    = in_busy ? addr_q  : '0;
        s_wdata   = in_busy ? wdata_q : '0;

        m0_ready  = in_resp & ~owner_q;
        m1_ready  = in_resp &  owner_q;
        m0_rdata  = m0_ready ? rsp_rdata_q : '0;
        m1_rdata  = m1_ready ? rsp_rdata_q : '0;
        m0_err    = m0_ready & rsp_err_q;
        m1_err    = m1_ready & rsp_err_q;

        arb_busy  = (state_q != ARB_IDLE);
        arb_owner = owner_q;
    end

    // Request latch, timeout counter, response capture and fairness pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tcnt_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    tcnt_q <= '0;
                    if (gnt_vld) begin
                        owner_q <= gnt_idx;
                        wr_q    <= sel_wr;
                        rd_q    <= sel_rd;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (req_malformed(sel_wr, sel_rd)) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ARB_BUSY: begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (s_ready) begin
                        rsp_rdata_q <= rd_q ? s_rdata : '0;
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    rr_ptr_q <= ~owner_q;
                    tcnt_q   <= '0;
                end
                default: begin
                    tcnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ita_bus_arb.sv
module tb_ita_bus_arb;

    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    typedef struct {
        logic        vld;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        req_t        r0;
        req_t        r1;
        int          delay;
        logic [31:0] sd;
        int          owner;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          sv;
    } vec_t;

    logic        clk, rst;
    logic        m0_valid, m0_wr, m0_rd, m1_valid, m1_wr, m1_rd;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_wr, s_rd, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        arb_busy, arb_owner;

    int n_chk  = 0;
    int n_fail = 0;

    int          slave_delay = NEVER;
    logic [31:0] slave_data  = 32'h0;
    int          busy_idx    = 0;

    ita_bus_arb dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_wr(s_wr), .s_rd(s_rd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        m0_valid = r0.vld; m0_wr = r0.wr; m0_rd = r0.rd; m0_addr = r0.addr; m0_wdata = r0.wdata;
        m1_valid = r1.vld; m1_wr = r1.wr; m1_rd = r1.rd; m1_addr = r1.addr; m1_wdata = r1.wdata;
    endtask

    // Advance one clock; behave as a slave that answers on busy cycle number slave_delay.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (s_valid) begin
            s_ready = (busy_idx == slave_delay);
            s_rdata = slave_data;
            busy_idx++;
        end else begin
            s_ready  = 1'b0;
            s_rdata  = $urandom;
            busy_idx = 0;
        end
    endtask

    function automatic req_t mk(input logic v, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        req_t x;
        x.vld = v; x.wr = w; x.rd = r; x.addr = a; x.wdata = d;
        return x;
    endfunction

    // One transaction from an idle arbiter; request fields are scrambled after grant to prove they are not resampled.
    task automatic run_txn(input vec_t v, input string name);
        req_t own, a0, a1;
        int   lat, svcnt, bad;
        bit   got;
        logic r0, r1, e0, e1;
        logic [31:0] d0, d1;
        own = (v.owner == 1) ? v.r1 : v.r0;
        slave_delay = v.delay;
        slave_data  = v.sd;
        drive(v.r0, v.r1);
        lat = 0; svcnt = 0; bad = 0; got = 0;
        r0 = 0; r1 = 0; e0 = 0; e1 = 0; d0 = 0; d1 = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            tick();
            if (s_valid) begin
                svcnt++;
                if (s_addr !== own.addr || s_wr !== own.wr || s_rd !== own.rd ||
                    s_wdata !== own.wdata || arb_owner !== 1'(v.owner)) bad++;
            end
            if (m0_ready || m1_ready) begin
                got = 1; lat = c;
                r0 = m0_ready; r1 = m1_ready; e0 = m0_err; e1 = m1_err; d0 = m0_rdata; d1 = m1_rdata;
            end else if (c == 1) begin
                a0 = v.r0; a1 = v.r1;
                a0.addr = ~a0.addr; a0.wdata = ~a0.wdata; a0.wr = ~a0.wr;
                a1.addr = ~a1.addr; a1.wdata = ~a1.wdata; a1.rd = ~a1.rd;
                drive(a0, a1);
            end
        end
        check({name, " resp_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, lat, v.lat);
        check({name, " owner_ready"}, {30'd0, r1, r0}, (v.owner == 1) ? 32'd2 : 32'd1);
        check({name, " rdata"}, (v.owner == 1) ? d1 : d0, v.rdata);
        check({name, " err"}, 32'((v.owner == 1) ? e1 : e0), 32'(v.err));
        check({name, " other_quiet"}, (v.owner == 1) ? (d0 | 32'(e0)) : (d1 | 32'(e1)), 32'd0);
        check({name, " s_valid_cycles"}, svcnt, v.sv);
        check({name, " slave_fields"}, bad, 0);
        drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
        tick();
        check({name, " idle_after"}, {30'd0, arb_busy, m0_ready | m1_ready}, 32'd0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   model_rr;
    int   dly_opts[9] = '{0, 1, 2, 3, 5, 14, 15, 16, 40};

    initial begin
        rst = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
        drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));

        // Table: rr pointer starts at 0 and flips to ~owner after every response.
        tbl[0] = '{mk(1,0,1,32'h0200_BFF8,0), mk(0,0,0,0,0), 0, 32'h1234_5678, 0, 32'h1234_5678, 0, 2, 1};
        tbl[1] = '{mk(0,0,0,0,0), mk(1,1,0,32'h0200_4000,32'hDEAD_BEEF), NEVER, 32'hAAAA_5555, 1, 0, 1, TMO+1, TMO};
        tbl[2] = '{mk(1,1,1,32'h0200_0000,32'h1), mk(0,0,0,0,0), 0, 32'h7777_7777, 0, 0, 1, 1, 0};
        tbl[3] = '{mk(1,0,1,32'h0200_0000,0), mk(1,0,1,32'h0200_4008,0), TMO-1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0, TMO+1, TMO};
        tbl[4] = '{mk(0,0,0,0,0), mk(1,0,0,32'h0200_BFFC,0), 0, 32'h1111_1111, 1, 0, 1, 1, 0};
        tbl[5] = '{mk(1,1,0,32'h0200_0004,32'h55AA),  mk(1,1,0,32'h0200_4004,32'hAA55), 3, 32'h9999_0000, 0, 0, 0, 5, 4};
        tbl[6] = '{mk(1,0,1,32'h0200_BFF8,0), mk(0,0,0,0,0), TMO-2, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, TMO, TMO-1};
        tbl[7] = '{mk(0,0,0,0,0), mk(1,0,1,32'h0200_BFFC,0), 1, 32'h4242_4242, 1, 32'h4242_4242, 0, 3, 2};

        for (int i = 0; i < 3; i++) tick();
        check("in_reset busy_valid", {30'd0, arb_busy, s_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("reset ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        check("reset rdata_err", m0_rdata | m1_rdata | 32'(m0_err) | 32'(m1_err), 32'd0);
        check("reset owner_busy", {30'd0, arb_owner, arb_busy}, 32'd0);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Both masters writing continuously: grants alternate M0,M1,M0,M1 every 3 cycles.
        begin
            int own_seq[4];
            int cyc_seq[4];
            int nresp, bad;
            nresp = 0; bad = 0;
            slave_delay = 0; slave_data = 32'h5555_5555;
            drive(mk(1,1,0,32'h0200_0000,32'h10), mk(1,1,0,32'h0200_4000,32'h20));
            for (int c = 1; c <= 40 && nresp < 4; c++) begin
                tick();
                if (s_valid && s_addr !== (arb_owner ? 32'h0200_4000 : 32'h0200_0000)) bad++;
                if (m0_ready || m1_ready) begin
                    own_seq[nresp] = m1_ready ? 1 : 0;
                    cyc_seq[nresp] = c;
                    if ((m0_rdata | m1_rdata | 32'(m0_err) | 32'(m1_err)) != 0) bad++;
                    nresp++;
                end
            end
            drive(mk(0,0,0,0,0), mk(0,0,0,0,0));
            tick();
            check("fair count", nresp, 4);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("fair owner%0d", k), own_seq[k], k % 2);
                check($sformatf("fair cycle%0d", k), cyc_seq[k], 2 + 3 * k);
            end
            check("fair fields", bad, 0);
        end

        // Reset mid-BUSY after an M0 grant (rr -> 1); afterwards a tie must go to M0 again.
        run_txn('{mk(1,0,1,32'h0200_BFF8,0), mk(0,0,0,0,0), 0, 32'h0000_00A5, 0, 32'h0000_00A5, 0, 2, 1}, "pre_rst");
        slave_delay = NEVER;
        drive(mk(1,0,1,32'h0200_BFF8,0), mk(0,0,0,0,0));
        for (int i = 0; i < 4; i++) tick();
        check("rst_mid s_valid_before", 32'(s_valid), 32'd1);
        rst = 1'b1;
        drive(mk(0,0,0,0,0), mk(0,0,0,0,0));
        tick();
        rst = 1'b0;
        check("rst_mid after", {29'd0, m1_ready, m0_ready, arb_busy, s_valid} & 32'hF, 32'd0);
        begin
            int nr;
            nr = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (m0_ready || m1_ready || s_valid) nr++;
            end
            check("rst_mid quiet", nr, 0);
        end
        run_txn('{mk(1,1,0,32'h0200_0000,32'h3), mk(1,1,0,32'h0200_4000,32'h4), 0, 32'h0, 0, 0, 0, 2, 1}, "post_rst");

        // Randomised traffic against a transaction-level model of grant, error and timing rules.
        model_rr = 1;
        for (int n = 0; n < 40; n++) begin
            int t0, t1, pick;
            logic v0, v1, malformed;
            req_t q0, q1, own;
            pick = $urandom_range(0, 2);
            v0 = (pick != 1); v1 = (pick != 0);
            t0 = $urandom_range(0, 9); t1 = $urandom_range(0, 9);
            q0 = mk(v0, (t0 < 4) || t0 == 8, (t0 >= 4) || t0 == 8, 32'h0200_0000 | ($urandom & 32'hFFFC), $urandom);
            q1 = mk(v1, (t1 < 4) || t1 == 9, (t1 >= 4) || t1 == 9, 32'h0200_0000 | ($urandom & 32'hFFFC), $urandom);
            if (t0 == 9) begin q0.wr = 0; q0.rd = 0; end
            if (t1 == 8) begin q1.wr = 0; q1.rd = 0; end
            rv.r0 = q0; rv.r1 = q1;
            rv.delay = dly_opts[$urandom_range(0, 8)];
            rv.sd = $urandom;
            rv.owner = (v0 && v1) ? model_rr : (v1 ? 1 : 0);
            own = (rv.owner == 1) ? q1 : q0;
            malformed = (own.wr == own.rd);
            rv.err = malformed || (rv.delay >= TMO);
            rv.rdata = (rv.err || own.wr) ? 32'h0 : rv.sd;
            rv.lat = malformed ? 1 : ((rv.delay < TMO) ? rv.delay + 2 : TMO + 1);
            rv.sv = malformed ? 0 : ((rv.delay < TMO) ? rv.delay + 1 : TMO);
            run_txn(rv, $sformatf("rnd%0d", n));
            model_rr = 1 - rv.owner;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
